// File: rtl/time_set_ctrl.sv
// time_set_ctrl: front end of the time-setting path.
// Synchronises and debounces the MODE/UP/DOWN buttons, steps the set-mode
// state machine and produces stretched, mutually exclusive step requests
// (up_n/down_n) that are long enough for the slow 1 Hz counters to sample.
module time_set_ctrl #(
    parameter int DEB_CYC     = 20,
    parameter int STRETCH_CYC = 1000,
    parameter int TIMEOUT_CYC = 30000
) (
    input  logic       clk_1kHz,
    input  logic       rst,
    input  logic       btn_mode_raw,
    input  logic       btn_up_raw,
    input  logic       btn_down_raw,
    output logic [2:0] mode,
    output logic       up_n,
    output logic       down_n
);

    localparam int DEB_W = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
    localparam int STR_W = $clog2(STRETCH_CYC + 1);
    localparam int TO_W  = $clog2(TIMEOUT_CYC);

    localparam int BTN_MODE = 0;
    localparam int BTN_UP   = 1;
    localparam int BTN_DOWN = 2;

    typedef enum logic [2:0] {
        RUN       = 3'b000,
        SET_SEC   = 3'b001,
        SET_HOUR  = 3'b010,
        SET_MIN   = 3'b011,
        SET_DAY   = 3'b100,
        SET_MONTH = 3'b101,
        SET_YEAR  = 3'b110
    } mode_t;

    logic [2:0] raw_vec;
    logic [2:0] deb_level;   // debounced levels, active-low
    logic [2:0] press;       // one-cycle pulse on each debounced 1->0 edge

    assign raw_vec = {btn_down_raw, btn_up_raw, btn_mode_raw};

    // ------------------------------------------------------------------
    // Per-button synchroniser and debouncer
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_btn
            logic             sync1_reg;
            logic             sync2_reg;
            logic             deb_reg;
            logic             deb_d_reg;
            logic [DEB_W-1:0] deb_cnt_reg;

            // Two-flop synchroniser, then accept a new level only after it
            // has been stable for DEB_CYC consecutive cycles.
            always_ff @(posedge clk_1kHz or posedge rst) begin
                if (rst) begin
                    sync1_reg   <= 1'b1;
                    sync2_reg   <= 1'b1;
                    deb_reg     <= 1'b1;
                    deb_d_reg   <= 1'b1;
                    deb_cnt_reg <= '0;
                end else begin
                    sync1_reg <= raw_vec[gi];
                    sync2_reg <= sync1_reg;
                    deb_d_reg <= deb_reg;
                    if (sync2_reg == deb_reg) begin
                        deb_cnt_reg <= '0;
                    end else if (deb_cnt_reg == DEB_W'(DEB_CYC - 1)) begin
                        deb_reg     <= sync2_reg;
                        deb_cnt_reg <= '0;
                    end else begin
                        deb_cnt_reg <= deb_cnt_reg + DEB_W'(1);
                    end
                end
            end

            assign deb_level[gi] = deb_reg;
            assign press[gi]     = deb_d_reg & ~deb_reg;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Mode FSM, timeout and step-request stretching
    // ------------------------------------------------------------------
    mode_t            mode_reg;
    mode_t            mode_next;
    logic             up_n_reg;
    logic             down_n_reg;
    logic [STR_W-1:0] str_cnt_reg;
    logic [TO_W-1:0]  to_cnt_reg;
    logic             any_low;
    logic             timeout_hit;
    logic             in_set;

    assign any_low     = ~&deb_level;
    assign in_set      = (mode_reg != RUN);
    assign timeout_hit = in_set && !any_low && (to_cnt_reg == TO_W'(TIMEOUT_CYC - 1));

    // Next mode in the MODE-button cycle
    always_comb begin
        mode_next = RUN;
        case (mode_reg)
            RUN:       mode_next = SET_SEC;
            SET_SEC:   mode_next = SET_HOUR;
            SET_HOUR:  mode_next = SET_MIN;
            SET_MIN:   mode_next = SET_DAY;
            SET_DAY:   mode_next = SET_MONTH;
            SET_MONTH: mode_next = SET_YEAR;
            default:   mode_next = RUN;
        endcase
    end

    // MODE press and timeout take priority and always cancel a stretch,
    // so mode never moves while a step request is low.
    always_ff @(posedge clk_1kHz or posedge rst) begin
        if (rst) begin
            mode_reg    <= RUN;
            up_n_reg    <= 1'b1;
            down_n_reg  <= 1'b1;
            str_cnt_reg <= '0;
            to_cnt_reg  <= '0;
        end else if (press[BTN_MODE]) begin
            mode_reg    <= mode_next;
            up_n_reg    <= 1'b1;
            down_n_reg  <= 1'b1;
            str_cnt_reg <= '0;
            to_cnt_reg  <= '0;
        end else if (timeout_hit) begin
            mode_reg    <= RUN;
            up_n_reg    <= 1'b1;
            down_n_reg  <= 1'b1;
            str_cnt_reg <= '0;
            to_cnt_reg  <= '0;
        end else begin
            if (!in_set || any_low) begin
                to_cnt_reg <= '0;
            end else begin
                to_cnt_reg <= to_cnt_reg + TO_W'(1);
            end

            // str_cnt counts low cycles of the active request, saturating
            // once the minimum width is met; the request then persists
            // while its button stays held (auto-repeat).
            if (!up_n_reg) begin
                if (str_cnt_reg >= STR_W'(STRETCH_CYC) && deb_level[BTN_UP]) begin
                    up_n_reg    <= 1'b1;
                    str_cnt_reg <= '0;
                end else if (str_cnt_reg < STR_W'(STRETCH_CYC)) begin
                    str_cnt_reg <= str_cnt_reg + STR_W'(1);
                end
            end else if (!down_n_reg) begin
                if (str_cnt_reg >= STR_W'(STRETCH_CYC) && deb_level[BTN_DOWN]) begin
                    down_n_reg  <= 1'b1;
                    str_cnt_reg <= '0;
                end else if (str_cnt_reg < STR_W'(STRETCH_CYC)) begin
                    str_cnt_reg <= str_cnt_reg + STR_W'(1);
                end
            end else if (in_set && press[BTN_UP]) begin
                up_n_reg    <= 1'b0;
                str_cnt_reg <= STR_W'(1);
            end else if (in_set && press[BTN_DOWN]) begin
                down_n_reg  <= 1'b0;
                str_cnt_reg <= STR_W'(1);
            end
        end
    end

    assign mode   = mode_reg;
    assign up_n   = up_n_reg;
    assign down_n = down_n_reg;

endmodule
